// File: rtl/fp_pool_tree.sv
// Streaming max/min pooling reducer for sign-magnitude floating-point windows.
// Binary comparator tree with one register level per stage, argmax/argmin index and stall-based back-pressure.
module fp_pool_tree #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN = 9,
    localparam int IDX_W = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] Data_In,
    input  logic                         Mode_In,
    input  logic                         Valid_In,
    output logic                         Ready_Out,
    output logic [DATA_WIDTH-1:0]        Data_Out,
    output logic [IDX_W-1:0]             Index_Out,
    output logic                         Valid_Out,
    input  logic                         Ready_In
);

    localparam int L = $clog2(NUM_IN);

    function automatic int survivors(input int level);
        int n;
        n = NUM_IN;
        for (int k = 0; k < level; k++) n = (n + 1) / 2;
        return n;
    endfunction

    // Maps sign-magnitude to a key whose unsigned order matches the numeric order (-0 < +0).
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x | {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    logic stall;

    assign stall     = Valid_Out & ~Ready_In;
    assign Ready_Out = ~stall;

    genvar j, p;
    generate
        for (j = 0; j < L; j++) begin : lvl
            localparam int NI = survivors(j);
            localparam int NO = survivors(j + 1);

            logic [DATA_WIDTH-1:0] in_val  [NI];
            logic [IDX_W-1:0]      in_idx  [NI];
            logic                  in_mode;
            logic                  in_valid;
            logic [DATA_WIDTH-1:0] win_val [NO];
            logic [IDX_W-1:0]      win_idx [NO];
            logic [DATA_WIDTH-1:0] val_q   [NO];
            logic [IDX_W-1:0]      idx_q   [NO];
            logic                  valid_q;

            if (j == 0) begin : g_src
                for (p = 0; p < NI; p++) begin : g_el
                    assign in_val[p] = Data_In[p*DATA_WIDTH +: DATA_WIDTH];
                    assign in_idx[p] = IDX_W'(p);
                end
                assign in_mode  = Mode_In;
                assign in_valid = Valid_In & Ready_Out;
            end else begin : g_src
                for (p = 0; p < NI; p++) begin : g_el
                    assign in_val[p] = lvl[j-1].val_q[p];
                    assign in_idx[p] = lvl[j-1].idx_q[p];
                end
                assign in_mode  = lvl[j-1].g_mode.mode_q;
                assign in_valid = lvl[j-1].valid_q;
            end

            // Left operand always carries the lower original index, so it keeps ties.
            for (p = 0; p < NO; p++) begin : g_pair
                if (2*p + 1 < NI) begin : g_cmp
                    logic [DATA_WIDTH-1:0] key_a;
                    logic [DATA_WIDTH-1:0] key_b;
                    logic                  take_b;
                    assign key_a      = order_key(in_val[2*p]);
                    assign key_b      = order_key(in_val[2*p+1]);
                    assign take_b     = in_mode ? (key_b < key_a) : (key_b > key_a);
                    assign win_val[p] = take_b ? in_val[2*p+1] : in_val[2*p];
                    assign win_idx[p] = take_b ? in_idx[2*p+1] : in_idx[2*p];
                end else begin : g_pass
                    assign win_val[p] = in_val[2*p];
                    assign win_idx[p] = in_idx[2*p];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    for (int k = 0; k < NO; k++) begin
                        val_q[k] <= '0;
                        idx_q[k] <= '0;
                    end
                end else if (!stall) begin
                    valid_q <= in_valid;
                    for (int k = 0; k < NO; k++) begin
                        val_q[k] <= win_val[k];
                        idx_q[k] <= win_idx[k];
                    end
                end
            end

            // The last level has no successor, so its mode bit is not kept.
            if (j < L - 1) begin : g_mode
                logic mode_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        mode_q <= 1'b0;
                    end else if (!stall) begin
                        mode_q <= in_mode;
                    end
                end
            end
        end
    endgenerate

    assign Data_Out  = lvl[L-1].val_q[0];
    assign Index_Out = lvl[L-1].idx_q[0];
    assign Valid_Out = lvl[L-1].valid_q;

endmodule

// File: tb/tb_fp_pool_tree.sv
// Self-checking bench for fp_pool_tree: directed cases, random streaming, back-pressure, reset and a parameter sweep.
// Expected results come from a numeric-rank reference model of the window.
module tb_fp_pool_tree;

    localparam int DW  = 32;
    localparam int NIN = 9;
    localparam int LAT = 4;
    localparam int SW_N = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NIN*DW-1:0] data_in;
    logic              mode_in;
    logic              valid_in;
    logic              ready_out;
    logic [DW-1:0]     data_out;
    logic [3:0]        index_out;
    logic              valid_out;
    logic              ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    fp_pool_tree #(.DATA_WIDTH(32), .NUM_IN(9)) dut (
        .clk(clk), .rst(rst), .Data_In(data_in), .Mode_In(mode_in), .Valid_In(valid_in),
        .Ready_Out(ready_out), .Data_Out(data_out), .Index_Out(index_out),
        .Valid_Out(valid_out), .Ready_In(ready_in)
    );

    // Sweep instances share one FP16 stimulus window; each sees its first NUM_IN elements.
    logic [255:0] sw_win;
    logic         sw_mode;
    logic         sw_valid;
    logic         sw_rdy [4];
    logic [15:0]  sw_d   [4];
    logic         sw_v   [4];
    logic [3:0]   sw_i   [4];
    logic [0:0]   idx_a;
    logic [1:0]   idx_b;
    logic [2:0]   idx_c;
    logic [3:0]   idx_d;

    assign sw_i[0] = {3'b000, idx_a};
    assign sw_i[1] = {2'b00, idx_b};
    assign sw_i[2] = {1'b0, idx_c};
    assign sw_i[3] = idx_d;

    fp_pool_tree #(.DATA_WIDTH(16), .NUM_IN(2)) dut_n2 (
        .clk(clk), .rst(rst), .Data_In(sw_win[31:0]), .Mode_In(sw_mode), .Valid_In(sw_valid),
        .Ready_Out(sw_rdy[0]), .Data_Out(sw_d[0]), .Index_Out(idx_a), .Valid_Out(sw_v[0]), .Ready_In(1'b1)
    );
    fp_pool_tree #(.DATA_WIDTH(16), .NUM_IN(4)) dut_n4 (
        .clk(clk), .rst(rst), .Data_In(sw_win[63:0]), .Mode_In(sw_mode), .Valid_In(sw_valid),
        .Ready_Out(sw_rdy[1]), .Data_Out(sw_d[1]), .Index_Out(idx_b), .Valid_Out(sw_v[1]), .Ready_In(1'b1)
    );
    fp_pool_tree #(.DATA_WIDTH(16), .NUM_IN(5)) dut_n5 (
        .clk(clk), .rst(rst), .Data_In(sw_win[79:0]), .Mode_In(sw_mode), .Valid_In(sw_valid),
        .Ready_Out(sw_rdy[2]), .Data_Out(sw_d[2]), .Index_Out(idx_c), .Valid_Out(sw_v[2]), .Ready_In(1'b1)
    );
    fp_pool_tree #(.DATA_WIDTH(16), .NUM_IN(16)) dut_n16 (
        .clk(clk), .rst(rst), .Data_In(sw_win[255:0]), .Mode_In(sw_mode), .Valid_In(sw_valid),
        .Ready_Out(sw_rdy[3]), .Data_Out(sw_d[3]), .Index_Out(idx_d), .Valid_Out(sw_v[3]), .Ready_In(1'b1)
    );

    // Numeric rank of a sign-magnitude word: negatives below -0, which sits just below +0.
    function automatic longint rank_of(input logic [31:0] e, input int dw);
        logic [63:0] m;
        m = {32'b0, e} & ((64'd1 << (dw - 1)) - 64'd1);
        if (e[dw-1]) return -longint'(m) - 1;
        return longint'(m);
    endfunction

    function automatic logic [31:0] elem_of(input logic [287:0] w, input int i, input int dw);
        logic [287:0] s;
        s = w >> (i * dw);
        if (dw == 32) return s[31:0];
        return {16'b0, s[15:0]};
    endfunction

    function automatic int ref_index(input logic [287:0] w, input int n, input int dw, input logic mode);
        int best;
        longint r;
        longint rb;
        best = 0;
        for (int i = 1; i < n; i++) begin
            r  = rank_of(elem_of(w, i, dw), dw);
            rb = rank_of(elem_of(w, best, dw), dw);
            if (mode ? (r < rb) : (r > rb)) best = i;
        end
        return best;
    endfunction

    function automatic logic [31:0] rand_elem(input int dw);
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = (dw == 32) ? 32'h7F800000 : 32'h00007C00;
            1: v = (dw == 32) ? 32'hFF800000 : 32'h0000FC00;
            2: v = (dw == 32) ? 32'h7FC00001 : 32'h00007E01;
            3: v = (dw == 32) ? 32'hFFC00000 : 32'h0000FE00;
            4: v = 32'h0;
            5: v = (dw == 32) ? 32'h80000000 : 32'h00008000;
            6, 7: begin
                if ($urandom_range(0, 1) == 1) v = (dw == 32) ? 32'h40000000 : 32'h00004000;
                else                           v = (dw == 32) ? 32'hC0000000 : 32'h0000C000;
            end
            default: v = (dw == 32) ? $urandom : {16'b0, 16'($urandom)};
        endcase
        return v;
    endfunction

    function automatic logic [287:0] rand_window(input int n, input int dw);
        logic [287:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = w | (288'(rand_elem(dw)) << (i * dw));
        return w;
    endfunction

    task automatic test_reset;
        valid_in = 1'b0; ready_in = 1'b1; mode_in = 1'b0; data_in = '0;
        sw_valid = 1'b0; sw_mode = 1'b0; sw_win = '0;
        #1 rst = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b, expected 0", valid_out); end
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %0h, expected 0", data_out); end
        n_checks++; if (index_out !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_index: got %0d, expected 0", index_out); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b, expected 1", ready_out); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valid: got %0b, expected 0", valid_out); end
    endtask

    task automatic test_directed;
        logic [31:0]  e [9];
        logic [31:0]  exp_d;
        int           exp_i;
        logic         m;
        int           lat;
        logic [287:0] w;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin e = '{32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 32'hC0E00000,
                               32'h41140000, 32'h40000000, 32'h41100000, 32'h80000000};
                         m = 1'b0; exp_d = 32'h41140000; exp_i = 5; end
                1: begin e = '{32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 32'hC0E00000,
                               32'h41140000, 32'h40000000, 32'h41100000, 32'h80000000};
                         m = 1'b1; exp_d = 32'hC0E00000; exp_i = 4; end
                2: begin e = '{default: 32'h40000000}; m = 1'b0; exp_d = 32'h40000000; exp_i = 0; end
                3: begin e = '{32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0400000, 32'hC0000000,
                               32'hC1200000, 32'hBF000000, 32'hC2C80000, 32'hC0800000};
                         m = 1'b0; exp_d = 32'h00000000; exp_i = 0; end
                default: begin e = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0400000, 32'hC0000000,
                               32'hC1200000, 32'hBF000000, 32'hC2C80000, 32'hC0800000};
                         m = 1'b0; exp_d = 32'h00000000; exp_i = 1; end
            endcase
            w = '0;
            for (int i = 0; i < 9; i++) w[i*32 +: 32] = e[i];
            @(negedge clk);
            data_in = w; mode_in = m; valid_in = 1'b1; ready_in = 1'b1;
            @(posedge clk);
            #1 valid_in = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!valid_out && lat < 10);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("[TB] FAIL directed%0d_latency: got %0d, expected %0d", k, lat, LAT); end
            n_checks++; if (data_out !== exp_d) begin n_fail++; $display("[TB] FAIL directed%0d_data: got %0h, expected %0h", k, data_out, exp_d); end
            n_checks++; if (index_out !== 4'(exp_i)) begin n_fail++; $display("[TB] FAIL directed%0d_index: got %0d, expected %0d", k, index_out, exp_i); end
            @(negedge clk);
            n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL directed%0d_pulse: got %0b, expected 0", k, valid_out); end
        end
    endtask

    task automatic test_streaming;
        logic [31:0]  exp_v [$];
        int           exp_i [$];
        logic [287:0] w;
        int sent = 0, got = 0, first = -1, last = -1, ei;
        ready_in = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
            @(negedge clk);
            #1;
            if (valid_out && ready_in) begin
                n_checks++;
                if (exp_v.size() == 0) begin
                    n_fail++; $display("[TB] FAIL stream_extra: got result %0h, expected none", data_out);
                end else begin
                    if (data_out !== exp_v[0] || index_out !== 4'(exp_i[0])) begin
                        n_fail++;
                        $display("[TB] FAIL stream_result%0d: got %0h/%0d, expected %0h/%0d", got, data_out, index_out, exp_v[0], exp_i[0]);
                    end
                    void'(exp_v.pop_front());
                    void'(exp_i.pop_front());
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (sent < 20) begin
                w = rand_window(9, 32);
                data_in = w; mode_in = 1'(sent % 2); valid_in = 1'b1;
                #1;
                if (ready_out) begin
                    ei = ref_index(w, 9, 32, mode_in);
                    exp_v.push_back(elem_of(w, ei, 32));
                    exp_i.push_back(ei);
                    sent++;
                end
            end else begin
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        n_checks++; if (got !== 20) begin n_fail++; $display("[TB] FAIL stream_count: got %0d, expected 20", got); end
        n_checks++; if (first !== LAT) begin n_fail++; $display("[TB] FAIL stream_latency: got %0d, expected %0d", first, LAT); end
        n_checks++; if (last - first !== 19) begin n_fail++; $display("[TB] FAIL stream_back_to_back: got span %0d, expected 19", last - first); end
    endtask

    task automatic test_back_pressure;
        logic [31:0]  exp_v [$];
        int           exp_i [$];
        logic [287:0] w;
        int sent = 0, got = 0, hold = 0, stall_cycles = 0, ei;
        bit stalled = 1'b0;
        w = rand_window(9, 32);
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            @(negedge clk);
            if (!stalled && valid_out && got == 2) begin
                stalled = 1'b1;
                hold = 3;
            end
            ready_in = (hold == 0);
            #1;
            if (hold > 0) begin
                hold--;
                stall_cycles++;
                n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_out: got %0b, expected 0", ready_out); end
                n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid_held: got %0b, expected 1", valid_out); end
                if (exp_v.size() > 0) begin
                    n_checks++; if (data_out !== exp_v[0]) begin n_fail++; $display("[TB] FAIL bp_data_held: got %0h, expected %0h", data_out, exp_v[0]); end
                end
            end
            if (valid_out && ready_in) begin
                n_checks++;
                if (exp_v.size() == 0) begin
                    n_fail++; $display("[TB] FAIL bp_extra: got result %0h, expected none", data_out);
                end else begin
                    if (data_out !== exp_v[0] || index_out !== 4'(exp_i[0])) begin
                        n_fail++;
                        $display("[TB] FAIL bp_result%0d: got %0h/%0d, expected %0h/%0d", got, data_out, index_out, exp_v[0], exp_i[0]);
                    end
                    void'(exp_v.pop_front());
                    void'(exp_i.pop_front());
                end
                got++;
            end
            if (sent < 6) begin
                data_in = w; mode_in = 1'(sent % 2); valid_in = 1'b1;
                #1;
                if (ready_out) begin
                    ei = ref_index(w, 9, 32, mode_in);
                    exp_v.push_back(elem_of(w, ei, 32));
                    exp_i.push_back(ei);
                    sent++;
                    w = rand_window(9, 32);
                end
            end else begin
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        n_checks++; if (got !== 6) begin n_fail++; $display("[TB] FAIL bp_count: got %0d, expected 6", got); end
        n_checks++; if (exp_v.size() !== 0) begin n_fail++; $display("[TB] FAIL bp_leftover: got %0d pending, expected 0", exp_v.size()); end
        n_checks++; if (stall_cycles !== 3) begin n_fail++; $display("[TB] FAIL bp_stall_cycles: got %0d, expected 3", stall_cycles); end
    endtask

    task automatic test_reset_mid_flight;
        ready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_in = rand_window(9, 32); mode_in = 1'(k % 2); valid_in = 1'b1;
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(posedge clk);
        #2;
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_valid_before: got %0b, expected 1", valid_out); end
        rst = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid_async: got %0b, expected 0", valid_out); end
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_data_async: got %0h, expected 0", data_out); end
        n_checks++; if (index_out !== 4'h0) begin n_fail++; $display("[TB] FAIL mid_index_async: got %0d, expected 0", index_out); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ready: got %0b, expected 1", ready_out); end
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_stale_c%0d: got %0b, expected 0", c, valid_out); end
        end
    endtask

    task automatic test_param_sweep;
        logic [287:0] hist_w [SW_N];
        logic         hist_m [SW_N];
        int           sw_nin [4];
        int           sw_lat [4];
        int           src, ei;
        logic         exp_valid;
        logic [31:0]  ed;
        sw_nin = '{2, 4, 5, 16};
        sw_lat = '{1, 2, 3, 4};
        for (int c = 0; c < SW_N + 5; c++) begin
            @(negedge clk);
            #1;
            if (c > 0) begin
                for (int u = 0; u < 4; u++) begin
                    src = (c - 1) - sw_lat[u] + 1;
                    exp_valid = (src >= 0 && src < SW_N);
                    n_checks++; if (sw_rdy[u] !== 1'b1) begin n_fail++; $display("[TB] FAIL sweep_ready_n%0d: got %0b, expected 1", sw_nin[u], sw_rdy[u]); end
                    n_checks++;
                    if (sw_v[u] !== exp_valid) begin
                        n_fail++; $display("[TB] FAIL sweep_valid_n%0d_c%0d: got %0b, expected %0b", sw_nin[u], c, sw_v[u], exp_valid);
                    end
                    if (exp_valid) begin
                        ei = ref_index(hist_w[src], sw_nin[u], 16, hist_m[src]);
                        ed = elem_of(hist_w[src], ei, 16);
                        n_checks++;
                        if (sw_d[u] !== ed[15:0] || sw_i[u] !== 4'(ei)) begin
                            n_fail++;
                            $display("[TB] FAIL sweep_result_n%0d_w%0d: got %0h/%0d, expected %0h/%0d", sw_nin[u], src, sw_d[u], sw_i[u], ed[15:0], ei);
                        end
                    end
                end
            end
            if (c < SW_N) begin
                hist_w[c] = rand_window(16, 16);
                hist_m[c] = 1'($urandom_range(0, 1));
                sw_win = hist_w[c][255:0];
                sw_mode = hist_m[c];
                sw_valid = 1'b1;
            end else begin
                sw_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] fp_pool_tree bench start");
        test_reset();
        test_directed();
        test_streaming();
        test_back_pressure();
        test_reset_mid_flight();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
